// File: rtl/vga_blank_mem_arbiter.sv
// rtl/vga_blank_mem_arbiter.sv - frame memory arbiter: VGA owns active video, two clients share blanking.
// Optional ARB_STATS_EN adds saturating transfer/stall counters.
module vga_blank_mem_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8,
  parameter int GUARD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iVGA_BLANK_N,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ready,
  output logic [1:0]        grant,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       xfer_cnt0,
  output logic [15:0]       xfer_cnt1,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {ST_ACTIVE, ST_SETTLE, ST_ARB, ST_OWN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_owner_q, last_owner_d;
  logic               held_vld_q, held_vld_d;
  logic               held_q, held_d;
  logic [CNT_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [1:0]         rvalid_q, rvalid_d;
  logic               own_sel;
  logic               arb_win;
  logic [1:0]         accept;

  assign own_sel = grant_q[1];
  assign arb_win = req[~last_owner_q] ? ~last_owner_q : last_owner_q;

  // Blank rising blocks access combinationally; reset suppresses any write in its own cycle.
  assign ready  = (state_q == ST_OWN && !iVGA_BLANK_N && !reset) ? (req & grant_q) : 2'b00;
  assign accept = req & ready;
  assign grant  = grant_q;
  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

  always_comb begin
    mem_addr  = vga_addr;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state_q == ST_OWN) begin
      mem_addr  = own_sel ? addr1 : addr0;
      mem_wdata = own_sel ? wdata1 : wdata0;
      mem_we    = |(accept & we);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    held_vld_d   = held_vld_q;
    held_d       = held_q;
    guard_cnt_d  = guard_cnt_q;
    rvalid_d     = accept & ~we;
    case (state_q)
      ST_ACTIVE: begin
        guard_cnt_d = '0;
        if (!iVGA_BLANK_N) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (iVGA_BLANK_N) begin
          state_d     = ST_ACTIVE;
          guard_cnt_d = '0;
        end else if (guard_cnt_q == CNT_W'(GUARD - 1)) begin
          guard_cnt_d = '0;
          held_vld_d  = 1'b0;
          // An interrupted owner that still requests resumes without re-arbitration.
          if (held_vld_q && req[held_q]) begin
            state_d = ST_OWN;
            grant_d = {held_q, ~held_q};
          end else begin
            state_d = ST_ARB;
            grant_d = 2'b00;
            if (held_vld_q) last_owner_d = held_q;
          end
        end else begin
          guard_cnt_d = guard_cnt_q + CNT_W'(1);
        end
      end
      ST_ARB: begin
        if (iVGA_BLANK_N) begin
          state_d = ST_ACTIVE;
        end else if (|req) begin
          state_d = ST_OWN;
          grant_d = {arb_win, ~arb_win};
        end
      end
      ST_OWN: begin
        if (!req[own_sel]) begin
          last_owner_d = own_sel;
          grant_d      = 2'b00;
          state_d      = iVGA_BLANK_N ? ST_ACTIVE : ST_ARB;
        end else if (iVGA_BLANK_N) begin
          state_d    = ST_ACTIVE;
          held_vld_d = 1'b1;
          held_d     = own_sel;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ACTIVE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
      held_vld_q   <= 1'b0;
      held_q       <= 1'b0;
      guard_cnt_q  <= '0;
      rvalid_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      held_vld_q   <= held_vld_d;
      held_q       <= held_d;
      guard_cnt_q  <= guard_cnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] xfer_cnt0_q, xfer_cnt0_d;
  logic [15:0] xfer_cnt1_q, xfer_cnt1_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    xfer_cnt0_d = xfer_cnt0_q;
    xfer_cnt1_d = xfer_cnt1_q;
    stall_cnt_d = stall_cnt_q;
    if (accept[0] && xfer_cnt0_q != 16'hFFFF) xfer_cnt0_d = xfer_cnt0_q + 16'd1;
    if (accept[1] && xfer_cnt1_q != 16'hFFFF) xfer_cnt1_d = xfer_cnt1_q + 16'd1;
    if (|(req & ~ready) && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt0_q <= '0;
      xfer_cnt1_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt0_q <= xfer_cnt0_d;
      xfer_cnt1_q <= xfer_cnt1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt0 = xfer_cnt0_q;
  assign xfer_cnt1 = xfer_cnt1_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_blank_mem_arbiter.sv
// tb/tb_vga_blank_mem_arbiter.sv - randomized self-checking bench for vga_blank_mem_arbiter.
module tb_vga_blank_mem_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int GUARD  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              iVGA_BLANK_N;
  logic [ADDR_W-1:0] vga_addr;
  logic [1:0]        req, we;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [1:0]        ready, grant, rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]       xfer_cnt0, xfer_cnt1, stall_cnt;
`endif

  vga_blank_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GUARD(GUARD)) dut (
    .clk(clk), .reset(reset), .iVGA_BLANK_N(iVGA_BLANK_N), .vga_addr(vga_addr),
    .req(req), .we(we), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ready(ready), .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .xfer_cnt0(xfer_cnt0), .xfer_cnt1(xfer_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Frame memory with one cycle of read latency
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  int checks = 0;
  int passed = 0;

  logic [DATA_W-1:0] ref_mem [0:4095];
  bit                c_act [2];
  bit                c_we [2];
  int                c_left [2];
  int                c_beats [2];
  logic [ADDR_W-1:0] c_addr [2];
  logic [DATA_W-1:0] c_wdata [2];
  bit                pend_rd [2];
  logic [ADDR_W-1:0] pend_addr [2];
  int                rv_cnt [2];
  logic [1:0]        grant_log [$];
  logic [1:0]        last_nz;
  logic [1:0]        rdy_s, gnt_s, first_rdy_val;
  int                steps, first_rdy, rdy_seen;

  task automatic clear_clients();
    for (int c = 0; c < 2; c++) begin
      c_act[c] = 0; c_we[c] = 0; c_left[c] = 0; c_beats[c] = 0;
      c_addr[c] = '0; c_wdata[c] = '0; pend_rd[c] = 0; pend_addr[c] = '0; rv_cnt[c] = 0;
    end
    grant_log.delete();
    last_nz = 2'b00;
  endtask

  task automatic start_burst(input int c, input bit w, input logic [ADDR_W-1:0] base, input int n);
    c_act[c] = 1; c_we[c] = w; c_addr[c] = base; c_left[c] = n; c_wdata[c] = DATA_W'($urandom);
  endtask

  task automatic drive();
    req      = {c_act[1], c_act[0]};
    we       = {c_we[1], c_we[0]};
    addr0    = c_addr[0];
    addr1    = c_addr[1];
    wdata0   = c_wdata[0];
    wdata1   = c_wdata[1];
    vga_addr = ADDR_W'($urandom);
  endtask

  // One clock of the client model: drive, observe at negedge, update scoreboard, advance.
  task automatic step();
    bit nxt_pend [2];
    drive();
    @(negedge clk);
    rdy_s = ready;
    gnt_s = grant;
    if (ready != 2'b00) begin
      rdy_seen++;
      if (first_rdy < 0) begin first_rdy = steps; first_rdy_val = ready; end
    end
    checks++;
    if (grant === 2'b11) $display("FAIL grant_onehot: got %b required at most one bit", grant);
    else passed++;
    if (grant != 2'b00 && grant != last_nz) begin grant_log.push_back(grant); last_nz = grant; end
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (rvalid[c] !== pend_rd[c]) $display("FAIL rvalid%0d: got %b required %b", c, rvalid[c], pend_rd[c]);
      else passed++;
      if (pend_rd[c]) begin
        if (rvalid[c] === 1'b1) rv_cnt[c]++;
        checks++;
        if (rdata !== ref_mem[pend_addr[c][11:0]])
          $display("FAIL rdata%0d: got %h required %h", c, rdata, ref_mem[pend_addr[c][11:0]]);
        else passed++;
      end
      nxt_pend[c] = 0;
      if (req[c] && ready[c] === 1'b1) begin
        if (c_we[c]) begin
          ref_mem[c_addr[c][11:0]] = c_wdata[c];
          checks++;
          if (mem_we !== 1'b1 || mem_addr !== c_addr[c] || mem_wdata !== c_wdata[c])
            $display("FAIL write%0d: got we=%b a=%h d=%h required we=1 a=%h d=%h",
                     c, mem_we, mem_addr, mem_wdata, c_addr[c], c_wdata[c]);
          else passed++;
        end else begin
          nxt_pend[c] = 1; pend_addr[c] = c_addr[c];
        end
        c_beats[c]++;
        c_addr[c] = c_addr[c] + 1'b1;
        c_wdata[c] = DATA_W'($urandom);
        c_left[c]--;
        if (c_left[c] == 0) c_act[c] = 0;
      end
    end
    pend_rd[0] = nxt_pend[0];
    pend_rd[1] = nxt_pend[1];
    steps++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; iVGA_BLANK_N = 1;
    clear_clients();
    drive();
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic run_until_idle(input string name, input int max_steps);
    int n = 0;
    while ((c_act[0] || c_act[1]) && n < max_steps) begin step(); n++; end
    checks++;
    if (c_act[0] || c_act[1]) $display("FAIL %s_timeout: got active=%b%b required idle", name, c_act[1], c_act[0]);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b required 00", grant); else passed++;
    checks++; if (ready !== 2'b00) $display("FAIL reset_ready: got %b required 00", ready); else passed++;
    checks++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b required 00", rvalid); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b required 0", mem_we); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_active();
    start_burst(0, 1, 19'h200, 4);
    for (int i = 0; i < 8; i++) begin
      drive();
      @(negedge clk);
      checks++; if (ready !== 2'b00) $display("FAIL active_ready: got %b required 00", ready); else passed++;
      checks++; if (mem_addr !== vga_addr) $display("FAIL active_addr: got %h required %h", mem_addr, vga_addr); else passed++;
      checks++; if (mem_we !== 1'b0) $display("FAIL active_we: got %b required 0", mem_we); else passed++;
      @(posedge clk); #1;
    end
    c_act[0] = 0;
  endtask

  task automatic test_guard_write();
    start_burst(0, 1, 19'h100, 4);
    iVGA_BLANK_N = 0; steps = 0; first_rdy = -1;
    run_until_idle("guard_write", 30);
    checks++;
    if (first_rdy != GUARD + 2) $display("FAIL guard_latency: got %0d required %0d", first_rdy, GUARD + 2);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[12'h100 + i] !== ref_mem[12'h100 + i])
        $display("FAIL guard_mem%0d: got %h required %h", i, mem[12'h100 + i], ref_mem[12'h100 + i]);
      else passed++;
    end
    step(); iVGA_BLANK_N = 1; step(); step();
  endtask

  task automatic test_round_robin();
    int left0;
    bit gap [2];
    do_reset();
    start_burst(0, 1, 19'h400, 3);
    start_burst(1, 1, 19'h480, 3);
    left0 = 1; gap[0] = 0; gap[1] = 0;
    for (int s = 0; s < 50; s++) begin
      iVGA_BLANK_N = (s >= 12 && s < 17) ? 1'b1 : 1'b0;
      step();
      if (!c_act[0] && left0 > 0) begin
        if (gap[0]) begin start_burst(0, 1, 19'h440, 3); left0--; gap[0] = 0; end
        else gap[0] = 1;
      end
      if (s > 17 && !c_act[0] && !c_act[1] && left0 == 0) break;
    end
    iVGA_BLANK_N = 1; step(); step();
    checks++;
    if (grant_log.size() != 3) $display("FAIL rr_order_len: got %0d required 3", grant_log.size());
    else if (grant_log[0] !== 2'b01 || grant_log[1] !== 2'b10 || grant_log[2] !== 2'b01)
      $display("FAIL rr_order: got %b,%b,%b required 01,10,01", grant_log[0], grant_log[1], grant_log[2]);
    else passed++;
    checks++;
    if (c_beats[0] != 6 || c_beats[1] != 3)
      $display("FAIL rr_beats: got %0d/%0d required 6/3", c_beats[0], c_beats[1]);
    else passed++;
  endtask

  task automatic test_resume();
    logic [ADDR_W-1:0] base;
    int n;
    do_reset();
    base = 19'h600 + ADDR_W'($urandom_range(0, 255));
    start_burst(0, 1, base, 10);
    iVGA_BLANK_N = 0;
    run_until_idle("resume_fill", 40);
    step(); iVGA_BLANK_N = 1; step(); step();
    c_beats[0] = 0;
    start_burst(1, 0, base, 10);
    iVGA_BLANK_N = 0;
    n = 0;
    while (c_beats[1] < 4 && n < 30) begin step(); n++; end
    iVGA_BLANK_N = 1;
    start_burst(0, 1, 19'h900, 5);
    step();
    checks++; if (rdy_s !== 2'b00) $display("FAIL resume_ready_drop: got %b required 00", rdy_s); else passed++;
    checks++; if (gnt_s !== 2'b10) $display("FAIL resume_grant_kept: got %b required 10", gnt_s); else passed++;
    for (int i = 0; i < 4; i++) step();
    checks++; if (gnt_s !== 2'b10) $display("FAIL resume_grant_held: got %b required 10", gnt_s); else passed++;
    checks++; if (rv_cnt[1] != 4) $display("FAIL resume_rvalid_first: got %0d required 4", rv_cnt[1]); else passed++;
    iVGA_BLANK_N = 0; steps = 0; first_rdy = -1;
    run_until_idle("resume", 60);
    step();
    checks++;
    if (first_rdy != GUARD + 1 || first_rdy_val !== 2'b10)
      $display("FAIL resume_latency: got %0d/%b required %0d/10", first_rdy, first_rdy_val, GUARD + 1);
    else passed++;
    checks++; if (rv_cnt[1] != 10) $display("FAIL resume_rvalid_total: got %0d required 10", rv_cnt[1]); else passed++;
    checks++; if (c_beats[0] != 5) $display("FAIL resume_r0_beats: got %0d required 5", c_beats[0]); else passed++;
    iVGA_BLANK_N = 1; step(); step();
  endtask

  task automatic test_short_blank();
    do_reset();
    start_burst(0, 1, 19'h700, 3);
    rdy_seen = 0;
    iVGA_BLANK_N = 0; step();
    iVGA_BLANK_N = 1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (rdy_seen != 0) $display("FAIL short_ready: got %0d required 0", rdy_seen); else passed++;
    drive();
    @(negedge clk);
    checks++; if (mem_addr !== vga_addr) $display("FAIL short_addr: got %h required %h", mem_addr, vga_addr); else passed++;
    @(posedge clk); #1;
    iVGA_BLANK_N = 0; steps = 0; first_rdy = -1;
    run_until_idle("short", 30);
    checks++;
    if (first_rdy != GUARD + 2) $display("FAIL short_latency: got %0d required %0d", first_rdy, GUARD + 2);
    else passed++;
    step(); iVGA_BLANK_N = 1; step();
  endtask

  task automatic test_reset_midburst();
    int n = 0;
    do_reset();
    start_burst(0, 1, 19'h800, 8);
    iVGA_BLANK_N = 0;
    while (c_beats[0] < 2 && n < 20) begin step(); n++; end
`ifdef ARB_STATS_EN
    checks++; if (xfer_cnt0 !== 16'd2) $display("FAIL stats_xfer0: got %0d required 2", xfer_cnt0); else passed++;
`endif
    reset = 1;
    drive();
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) $display("FAIL midburst_reset_we: got %b required 0", mem_we); else passed++;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) $display("FAIL midburst_grant: got %b required 00", grant); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL midburst_we: got %b required 0", mem_we); else passed++;
`ifdef ARB_STATS_EN
    checks++;
    if (xfer_cnt0 !== 16'd0 || xfer_cnt1 !== 16'd0 || stall_cnt !== 16'd0)
      $display("FAIL stats_clear: got %0d/%0d/%0d required 0/0/0", xfer_cnt0, xfer_cnt1, stall_cnt);
    else passed++;
`endif
    @(posedge clk); #1;
    clear_clients();
    iVGA_BLANK_N = 1;
  endtask

  initial begin
    reset = 1; iVGA_BLANK_N = 1;
    clear_clients();
    drive();
    test_reset();
    test_active();
    test_guard_write();
    test_round_robin();
    test_resume();
    test_short_blank();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
